pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//   Parametrised program-counter unit. It replaces the separate PC register,
//   +4 adder and PC source mux with one block.
//   - Holds the fetch PC and advances it by INC on each accepted fetch.
//   - Takes trap and branch redirects, in that priority, and checks branch
//     target alignment.
//   - Gives the fetch stage a valid/ready handshake and counts accepted fetches.
// PARAMETERS
//   XLEN          32            PC width in bits
//   RESET_VECTOR  32'h0000_0000 PC value loaded on reset (XLEN bits)
//   INC           4             sequential increment; must be a multiple of 2**ALIGN_BITS
//   ALIGN_BITS    2             low target bits that must be zero for a legal branch
//   CNT_W         16            width of the accepted-fetch counter
// PORTS
//   clk_i              in   1      clock, rising edge
//   rst_i              in   1      reset, asynchronous, active-low
//   stall_i            in   1      pipeline stall: hold PC, suppress fetch valid
//   branch_en_i        in   1      branch/jump redirect request
//   branch_target_i    in   XLEN   branch/jump target
//   trap_en_i          in   1      trap redirect request (highest priority)
//   trap_target_i      in   XLEN   trap handler address
//   pc_ready_i         in   1      fetch stage accepts pc_o this cycle
//   pc_o               out  XLEN   current fetch PC (registered)
//   pc_next_o          out  XLEN   pc_o + INC, modulo 2**XLEN (combinational)
//   pc_valid_o         out  1      pc_o is a fetch request
//   misaligned_o       out  1      one-cycle pulse: branch target was misaligned
//   misaligned_addr_o  out  XLEN   offending target, held until the next misalign event
//   fetch_count_o      out  CNT_W  number of accepted fetches, wraps
// BEHAVIOUR
//   Reset (rst_i=0, asynchronous):
//     - pc_o=RESET_VECTOR, state=BOOT, pc_valid_o=0, misaligned_o=0,
//       misaligned_addr_o=0, fetch_count_o=0.
//     - Asserting reset at any time aborts all activity immediately.
//   FSM, 2 states:
//     - BOOT: pc_valid_o=0 and all inputs ignored. Moves to RUN on the first
//       clock edge after reset is released.
//     - RUN: stays in RUN until reset.
//   pc_valid_o = (state==RUN) && !stall_i. This is combinational from stall_i.
//   Handshake:
//     - fire = pc_valid_o && pc_ready_i.
//     - On fire, fetch_count_o increments next cycle and wraps at 2**CNT_W.
//     - pc_o must not change while pc_valid_o=1 && !pc_ready_i, unless a
//       redirect is taken.
//   Next-PC selection in RUN, evaluated every edge, first match wins:
//     1. trap_en_i=1: pc_o <= trap_target_i with low ALIGN_BITS forced to 0.
//        Taken even when stall_i=1 or pc_ready_i=0.
//     2. branch_en_i=1 and target[ALIGN_BITS-1:0]==0: pc_o <= branch_target_i.
//        Taken even when stall_i=1 or pc_ready_i=0.
//     3. branch_en_i=1 and target misaligned: pc_o is NOT redirected. It
//        advances by INC if fire, else holds. Next cycle misaligned_o=1 and
//        misaligned_addr_o=branch_target_i.
//     4. fire: pc_o <= pc_o + INC, wrapping modulo 2**XLEN.
//     5. otherwise: pc_o holds.
//   Redirect in the same cycle as fire:
//     - The old pc_o counts as accepted and fetch_count_o increments.
//     - pc_o takes the redirect target, not pc_o + INC.
//   trap_en_i and branch_en_i together: the trap wins, and a misaligned branch
//     target is NOT flagged.
//   Latency: a redirect is visible on pc_o one cycle after it is requested,
//     with pc_valid_o=1 when not stalled.
//   misaligned_o is high for exactly one cycle per misaligned request.
// TESTING
//   1. Reset, release on edge 0 -> pc_valid_o=0 at edge 1, then =1 with
//      pc_o=0x0 at edge 2; with pc_ready_i=1 pc_o steps 0x4, 0x8, 0xC.
//   2. pc_ready_i=0 for 3 cycles at pc_o=0x8 -> pc_o holds 0x8 and
//      fetch_count_o is unchanged; ready=1 -> pc_o becomes 0xC and the count
//      increments by 1.
//   3. branch_en_i=1, target 0x100, same cycle as fire at pc_o=0x10 ->
//      pc_o=0x100 next cycle; count +1; misaligned_o=0.
//   4. branch_en_i=1, target 0x102 at pc_o=0x20, ready=1 -> pc_o=0x24,
//      misaligned_o pulses once, misaligned_addr_o=0x102.
//   5. trap_en_i=1 (target 0x203) with branch_en_i=1 (target 0x101) and
//      stall_i=1 -> pc_o=0x200; no misaligned pulse; pc_valid_o=0 until stall
//      drops.
//   6. pc_o=0xFFFF_FFFC, fire -> pc_o=0x0. fetch_count_o=0xFFFF, fire ->
//      0x0000. rst_i pulled low mid-stream -> outputs take reset values
//      immediately, before the next clock edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC register, sequential increment, trap/branch
// redirect with alignment check, fetch handshake and accepted-fetch counter.
module pc_unit #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          INC          = 4,
  parameter int unsigned          ALIGN_BITS   = 2,
  parameter int unsigned          CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_en_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic             trap_en_i,
  input  logic [XLEN-1:0]  trap_target_i,
  input  logic             pc_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_next_o,
  output logic             pc_valid_o,
  output logic             misaligned_o,
  output logic [XLEN-1:0]  misaligned_addr_o,
  output logic [CNT_W-1:0] fetch_count_o
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t state;
  logic   fire;
  logic   branch_aligned;

  always_comb begin
    pc_next_o      = pc_o + XLEN'(INC);
    pc_valid_o     = (state == RUN) && !stall_i;
    fire           = pc_valid_o && pc_ready_i;
    branch_aligned = (branch_target_i & ALIGN_MASK) == '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state             <= BOOT;
      pc_o              <= RESET_VECTOR;
      misaligned_o      <= 1'b0;
      misaligned_addr_o <= '0;
      fetch_count_o     <= '0;
    end else begin
      misaligned_o <= 1'b0;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (fire)
            fetch_count_o <= fetch_count_o + CNT_W'(1);
          if (trap_en_i) begin
            pc_o <= trap_target_i & ~ALIGN_MASK;
          end else if (branch_en_i && branch_aligned) begin
            pc_o <= branch_target_i;
          end else begin
            // A misaligned branch is reported but the fetch stream carries on.
            if (branch_en_i) begin
              misaligned_o      <= 1'b1;
              misaligned_addr_o <= branch_target_i;
            end
            if (fire)
              pc_o <= pc_next_o;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the fetch PC rules.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_t = '0;
  logic        trap_en = 1'b0;
  logic [31:0] tr_t = '0;
  logic        ready = 1'b0;

  logic [31:0] pc, pc_next, mis_addr;
  logic        valid, mis;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit          m_run;
  logic [31:0] m_pc, m_addr;
  bit          m_mis;
  logic [15:0] m_cnt;

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .INC(4), .ALIGN_BITS(2), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall),
    .branch_en_i(br_en), .branch_target_i(br_t),
    .trap_en_i(trap_en), .trap_target_i(tr_t),
    .pc_ready_i(ready),
    .pc_o(pc), .pc_next_o(pc_next), .pc_valid_o(valid),
    .misaligned_o(mis), .misaligned_addr_o(mis_addr),
    .fetch_count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_addr = 32'h0; m_mis = 0; m_cnt = 16'h0;
  endtask

  // Applies the PC rules for one rising edge using the inputs held across it.
  task automatic model_edge();
    bit fire;
    if (!rst_i) begin
      model_reset();
      return;
    end
    if (!m_run) begin
      m_run = 1;
      return;
    end
    fire  = !stall && ready;
    m_mis = 0;
    if (fire) m_cnt = m_cnt + 16'd1;
    if (trap_en)
      m_pc = tr_t - (tr_t % 4);
    else if (br_en && (br_t % 4) == 0)
      m_pc = br_t;
    else begin
      if (br_en) begin
        m_mis  = 1;
        m_addr = br_t;
      end
      if (fire) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("pc_next", pc_next, m_pc + 32'd4);
    chk("valid", {31'b0, valid}, {31'b0, m_run && !stall});
    chk("misaligned", {31'b0, mis}, {31'b0, m_mis});
    chk("mis_addr", mis_addr, m_addr);
    chk("count", {16'b0, cnt}, {16'b0, m_cnt});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] cnt_before;
    model_reset();

    // 1: reset state, boot, sequential stepping
    ready = 1'b1;
    #2;
    check_all();
    chk("rst_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    cycle();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'b0, valid}, 32'h1);
    cycle(); chk("step4", pc, 32'h4);
    cycle(); chk("step8", pc, 32'h8);

    // 2: backpressure holds pc and count
    ready = 1'b0;
    cnt_before = cnt;
    repeat (3) cycle();
    chk("hold_pc", pc, 32'h8);
    chk("hold_cnt", {16'b0, cnt}, {16'b0, cnt_before});
    ready = 1'b1;
    cycle();
    chk("release_pc", pc, 32'hC);
    chk("release_cnt", {16'b0, cnt}, {16'b0, cnt_before + 16'd1});
    cycle();
    chk("pc10", pc, 32'h10);

    // 3: aligned branch with fire
    cnt_before = cnt;
    br_en = 1'b1; br_t = 32'h100;
    cycle();
    chk("branch_pc", pc, 32'h100);
    chk("branch_cnt", {16'b0, cnt}, {16'b0, cnt_before + 16'd1});
    chk("branch_nomis", {31'b0, mis}, 32'h0);

    // 4: misaligned branch at 0x20
    br_t = 32'h20;
    cycle();
    br_t = 32'h102;
    cycle();
    chk("mis_pc", pc, 32'h24);
    chk("mis_pulse", {31'b0, mis}, 32'h1);
    chk("mis_addr_val", mis_addr, 32'h102);
    br_en = 1'b0;
    cycle();
    chk("mis_once", {31'b0, mis}, 32'h0);
    chk("mis_addr_held", mis_addr, 32'h102);

    // 5: trap beats misaligned branch under stall
    stall = 1'b1;
    trap_en = 1'b1; tr_t = 32'h203;
    br_en = 1'b1; br_t = 32'h101;
    cycle();
    chk("trap_pc", pc, 32'h200);
    chk("trap_nomis", {31'b0, mis}, 32'h0);
    chk("trap_stall_valid", {31'b0, valid}, 32'h0);
    trap_en = 1'b0; br_en = 1'b0;
    cycle();
    chk("stall_hold", pc, 32'h200);
    stall = 1'b0;
    #1;
    check_all();
    chk("unstall_valid", {31'b0, valid}, 32'h1);

    // 6: pc wrap, counter wrap
    br_en = 1'b1; br_t = 32'hFFFF_FFFC;
    cycle();
    br_en = 1'b0;
    chk("pc_top", pc, 32'hFFFF_FFFC);
    cycle();
    chk("pc_wrap", pc, 32'h0);
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) cycle();
    chk("cnt_top", {16'b0, cnt}, 32'h0000_FFFF);
    cycle();
    chk("cnt_wrap", {16'b0, cnt}, 32'h0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      stall   = ($urandom_range(3) == 0);
      ready   = ($urandom_range(3) != 0);
      br_en   = ($urandom_range(7) == 0);
      br_t    = $urandom;
      if ($urandom_range(1) == 0) br_t[1:0] = 2'b00;
      trap_en = ($urandom_range(15) == 0);
      tr_t    = $urandom;
      cycle();
    end

    // asynchronous reset mid-stream
    stall = 1'b0; ready = 1'b1; br_en = 1'b0; trap_en = 1'b0;
    repeat (3) cycle();
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_pc", pc, 32'h0);
    chk("async_cnt", {16'b0, cnt}, 32'h0);
    chk("async_valid", {31'b0, valid}, 32'h0);
    cycle();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (4) cycle();
    chk("after_rst_pc", pc, 32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
